// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus request/response types and the arbiter FSM state encoding.
package cbus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {IDLE, BUSY} cbus_arb_state_t;

endpackage

// File: rtl/cbus_arbiter_picker.sv
// rr_priority_picker: first set bit of a valid mask, searching upward from start and wrapping.
module rr_priority_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest valid candidate is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(start) + k) % NREQ);
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Burst-granular arbiter sharing one memory cbus among NREQ cache ports.
// Define CBUS_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NREQ],
  output cbus_resp_t iresps [NREQ],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  cbus_arb_state_t  state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [NREQ-1:0]  valid_mask;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_port
      assign valid_mask[gi] = ireqs[gi].valid;
      // Only the granted port ever sees the memory response.
      assign iresps[gi] = (state_reg == BUSY && idx_reg == IDX_W'(gi)) ? oresp : '0;
    end
  endgenerate

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_grant_reg;

  assign start_idx = (last_grant_reg == IDX_W'(NREQ - 1)) ? '0 : last_grant_reg + IDX_W'(1);

  // Reset value makes the very first search start at port 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= IDX_W'(NREQ - 1);
    end else if (state_reg == IDLE && pick_found) begin
      last_grant_reg <= pick_idx;
    end
  end
`else
  assign start_idx = '0;
`endif

  rr_priority_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid (valid_mask),
    .start (start_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            idx_reg   <= pick_idx;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oreq = (state_reg == BUSY) ? ireqs[idx_reg] : '0;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter; rotating-priority expectations apply when CBUS_ARB_ROUND_ROBIN_EN is defined.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs  [2];
  cbus_resp_t iresps [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int checks;
  int failures;

  cbus_arbiter #(.NREQ(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len);
    cbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.len    = len;
    r.data   = {32'hCAFE0000, addr};
    r.strobe = 8'hFF;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic last, input logic [63:0] data);
    cbus_resp_t r;
    r.ready = 1'b1;
    r.last  = last;
    r.data  = data;
    return r;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    ireqs[0] = mk_req(32'h10, 8'd0);
    ireqs[1] = mk_req(32'h20, 8'd0);
    oresp    = mk_resp(1'b1, 64'h55);
    repeat (2) cyc();
    checks++;
    if (oreq !== '0) begin
      failures++; $display("FAIL reset_oreq: got %h expected 0", oreq);
    end
    checks++;
    if (iresps[0] !== '0 || iresps[1] !== '0) begin
      failures++; $display("FAIL reset_iresps: got %h %h expected 0 0", iresps[0], iresps[1]);
    end
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp    = '0;
    settle();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_burst;
    cbus_req_t exp;
    exp      = mk_req(32'h200, 8'd3);
    ireqs[0] = exp;
    cyc();
    checks++;
    if (oreq !== exp) begin
      failures++; $display("FAIL midrst_grant: got %h expected %h", oreq, exp);
    end
    oresp = mk_resp(1'b0, 64'h1);
    settle();
    checks++;
    if (iresps[0].ready !== 1'b1) begin
      failures++; $display("FAIL midrst_beat1: got ready=%b expected 1", iresps[0].ready);
    end
    cyc();
    oresp = mk_resp(1'b0, 64'h2);
    settle();
    reset = 1'b0;
    settle();
    checks++;
    if (oreq.valid !== 1'b0 || iresps[0] !== '0 || iresps[1] !== '0) begin
      failures++; $display("FAIL midrst_abort: got valid=%b iresp0=%h iresp1=%h expected 0 0 0",
                           oreq.valid, iresps[0], iresps[1]);
    end
    ireqs[0] = '0;
    settle();
    reset = 1'b1;
    cyc();
    checks++;
    if (oreq.valid !== 1'b0 || iresps[0].ready !== 1'b0) begin
      failures++; $display("FAIL midrst_idle: got valid=%b ready0=%b expected 0 0", oreq.valid, iresps[0].ready);
    end
    oresp = '0;
  endtask

  task automatic test_port1_burst;
    cbus_req_t  exp;
    cbus_resp_t rsp;
    exp      = mk_req(32'h100, 8'd3);
    ireqs[1] = exp;
    settle();
    checks++;
    if (oreq.valid !== 1'b0) begin
      failures++; $display("FAIL p1_latency: got valid=%b in request cycle expected 0", oreq.valid);
    end
    cyc();
    checks++;
    if (oreq !== exp) begin
      failures++; $display("FAIL p1_forward: got %h expected %h", oreq, exp);
    end
    for (int b = 0; b < 4; b++) begin
      rsp   = mk_resp(b == 3, 64'hA0 + 64'(b));
      oresp = rsp;
      settle();
      checks++;
      if (iresps[1] !== rsp || iresps[0] !== '0 || oreq.valid !== 1'b1) begin
        failures++; $display("FAIL p1_beat%0d: got iresp1=%h iresp0=%h valid=%b expected %h 0 1",
                             b, iresps[1], iresps[0], oreq.valid, rsp);
      end
      cyc();
    end
    oresp = '0;
    settle();
    checks++;
    if (oreq.valid !== 1'b0) begin
      failures++; $display("FAIL p1_bubble: got valid=%b after last expected 0", oreq.valid);
    end
    ireqs[1] = '0;
    cyc();
  endtask

  task automatic test_both_same_cycle;
    ireqs[0] = mk_req(32'h300, 8'd0);
    ireqs[1] = mk_req(32'h310, 8'd0);
    cyc();
    checks++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h300) begin
      failures++; $display("FAIL both_first: got valid=%b addr=%h expected 1 300", oreq.valid, oreq.addr);
    end
    oresp = mk_resp(1'b1, 64'h3);
    settle();
    checks++;
    if (iresps[0].ready !== 1'b1 || iresps[1].ready !== 1'b0) begin
      failures++; $display("FAIL both_route0: got ready0=%b ready1=%b expected 1 0", iresps[0].ready, iresps[1].ready);
    end
    ireqs[0] = '0;
    cyc();
    oresp = '0;
    settle();
    checks++;
    if (oreq.valid !== 1'b0) begin
      failures++; $display("FAIL both_bubble: got valid=%b expected 0", oreq.valid);
    end
    cyc();
    checks++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h310) begin
      failures++; $display("FAIL both_second: got valid=%b addr=%h expected 1 310", oreq.valid, oreq.addr);
    end
    oresp = mk_resp(1'b1, 64'h4);
    settle();
    checks++;
    if (iresps[1].ready !== 1'b1 || iresps[0].ready !== 1'b0) begin
      failures++; $display("FAIL both_route1: got ready1=%b ready0=%b expected 1 0", iresps[1].ready, iresps[0].ready);
    end
    ireqs[1] = '0;
    cyc();
    oresp = '0;
    cyc();
  endtask

  task automatic test_back_to_back;
    int exp_port;
    logic [31:0] addrs [2];
    addrs[0] = 32'h700;
    addrs[1] = 32'h710;
    ireqs[0] = mk_req(addrs[0], 8'd0);
    ireqs[1] = mk_req(addrs[1], 8'd0);
    for (int n = 0; n < 4; n++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      exp_port = n % 2;
`else
      exp_port = 0;
`endif
      cyc();
      checks++;
      if (oreq.valid !== 1'b1 || oreq.addr !== addrs[exp_port]) begin
        failures++; $display("FAIL b2b_grant%0d: got valid=%b addr=%h expected 1 %h",
                             n, oreq.valid, oreq.addr, addrs[exp_port]);
      end
      oresp = mk_resp(1'b1, 64'(n));
      settle();
      checks++;
      if (iresps[exp_port].ready !== 1'b1 || iresps[1 - exp_port].ready !== 1'b0) begin
        failures++; $display("FAIL b2b_route%0d: got ready_win=%b ready_lose=%b expected 1 0",
                             n, iresps[exp_port].ready, iresps[1 - exp_port].ready);
      end
      cyc();
      oresp = '0;
      settle();
      checks++;
      if (oreq.valid !== 1'b0) begin
        failures++; $display("FAIL b2b_bubble%0d: got valid=%b expected 0", n, oreq.valid);
      end
    end
    ireqs[0] = '0;
    ireqs[1] = '0;
    cyc();
  endtask

  task automatic test_loser_blocked;
    ireqs[1] = mk_req(32'h500, 8'd1);
    cyc();
    checks++;
    if (oreq.addr !== 32'h500 || oreq.valid !== 1'b1) begin
      failures++; $display("FAIL lose_grant1: got valid=%b addr=%h expected 1 500", oreq.valid, oreq.addr);
    end
    ireqs[0] = mk_req(32'h400, 8'd0);
    oresp    = mk_resp(1'b0, 64'h50);
    settle();
    checks++;
    if (iresps[0].ready !== 1'b0 || iresps[1].ready !== 1'b1 || oreq.addr !== 32'h500) begin
      failures++; $display("FAIL lose_beat0: got ready0=%b ready1=%b addr=%h expected 0 1 500",
                           iresps[0].ready, iresps[1].ready, oreq.addr);
    end
    cyc();
    oresp = mk_resp(1'b1, 64'h51);
    settle();
    checks++;
    if (iresps[0] !== '0 || iresps[1].last !== 1'b1) begin
      failures++; $display("FAIL lose_last: got iresp0=%h last1=%b expected 0 1", iresps[0], iresps[1].last);
    end
    cyc();
    ireqs[1] = '0;
    oresp    = '0;
    settle();
    checks++;
    if (oreq.valid !== 1'b0) begin
      failures++; $display("FAIL lose_bubble: got valid=%b expected 0", oreq.valid);
    end
    cyc();
    checks++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h400) begin
      failures++; $display("FAIL lose_then0: got valid=%b addr=%h expected 1 400", oreq.valid, oreq.addr);
    end
    oresp = mk_resp(1'b1, 64'h40);
    settle();
    checks++;
    if (iresps[0].ready !== 1'b1) begin
      failures++; $display("FAIL lose_route0: got ready0=%b expected 1", iresps[0].ready);
    end
    ireqs[0] = '0;
    cyc();
    oresp = '0;
    cyc();
  endtask

  task automatic test_single_beat;
    cbus_resp_t rsp;
    ireqs[0] = mk_req(32'h600, 8'd0);
    cyc();
    checks++;
    if (oreq.valid !== 1'b1 || oreq.len !== 8'd0) begin
      failures++; $display("FAIL sb_grant: got valid=%b len=%0d expected 1 0", oreq.valid, oreq.len);
    end
    rsp   = mk_resp(1'b1, 64'h66);
    oresp = rsp;
    settle();
    checks++;
    if (iresps[0] !== rsp) begin
      failures++; $display("FAIL sb_beat: got %h expected %h", iresps[0], rsp);
    end
    cyc();
    checks++;
    if (oreq.valid !== 1'b0 || iresps[0].ready !== 1'b0) begin
      failures++; $display("FAIL sb_one_beat: got valid=%b ready0=%b expected 0 0", oreq.valid, iresps[0].ready);
    end
    ireqs[0] = '0;
    oresp    = '0;
    cyc();
    checks++;
    if (oreq.valid !== 1'b0) begin
      failures++; $display("FAIL sb_idle: got valid=%b expected 0", oreq.valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp    = '0;
    test_reset();
    test_reset_mid_burst();
    test_port1_burst();
    test_both_same_cycle();
    test_back_to_back();
    test_loser_blocked();
    test_single_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
